lru_tag_cache: RTL
==================

Name: lru_tag_cache

Overview:
- Parametrised, fully associative LRU tag directory for the box_250mhz cache utilities. It is the successor to the fixed 8-entry LRU way.
- Handles lookups over a valid/ready stream, reports hit/miss and a slot index, and on miss either allocates (evicting the LRU entry) or only probes, selected per request.
- Adds tag invalidation, global flush, a valid bit per slot and hit/miss statistics.
- The data array lives outside this block and is indexed by the returned slot.

Parameters:
- TAGS_WIDTH, 48, tag width in bits.
- CACHE_DEPTH, 8, number of slots; legal range 2..64.
- CNT_WIDTH, 32, width of the statistics counters.
- RESET_TAG, 48'h0000_DEADC0DE, tag value loaded into every slot at reset (slots are also invalid).

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- s_lkp_tvalid  in  1  lookup request valid.
- s_lkp_tready  out  1  lookup accepted when tvalid & tready.
- s_lkp_tdata  in  TAGS_WIDTH  lookup tag.
- s_lkp_tuser  in  1  1 = allocate on miss, 0 = probe only.
- m_rsp_tvalid  out  1  response valid.
- m_rsp_tready  in  1  response consumer ready.
- m_rsp_hit  out  1  lookup hit.
- m_rsp_slot  out  SLOT_W  slot that hit or was allocated; 0 on probe miss. SLOT_W = clogb2(CACHE_DEPTH-1).
- m_rsp_evict_valid  out  1  a valid entry was evicted.
- m_rsp_evict_tag  out  TAGS_WIDTH  evicted tag.
- inv_valid  in  1  invalidate request, single cycle.
- inv_tag  in  TAGS_WIDTH  tag to invalidate.
- flush  in  1  single-cycle pulse; clears all valid bits.
- hit_cnt  out  CNT_WIDTH  accepted hits, wraps.
- miss_cnt  out  CNT_WIDTH  accepted misses, wraps.

Behaviour:
- State:
  - tag[i] and valid[i] per slot.
  - order[0..DEPTH-1] is a permutation of slot indices; order[0] is MRU, order[DEPTH-1] is LRU.
- Reset (rstn low, asynchronous):
  - valid all 0, tag[i] = RESET_TAG, order[i] = i.
  - m_rsp_tvalid, m_rsp_hit, m_rsp_slot, m_rsp_evict_valid, m_rsp_evict_tag, hit_cnt and miss_cnt all 0.
- Hit detection: a slot hits when tag[i] == s_lkp_tdata and valid[i]. At most one slot hits (invariant); if several match, the lowest index wins.
- Handshake: s_lkp_tready = (!m_rsp_tvalid | m_rsp_tready) & !inv_valid & !flush.
- Latency:
  - The response is registered and appears the cycle after the accept.
  - m_rsp_tvalid holds, with its payload stable, until m_rsp_tready.
  - Full throughput: one lookup per cycle when m_rsp_tready stays high.
- On accept, hit at slot s (position p in order):
  - order[0] = s; order[1..p] = old order[0..p-1]; order[p+1..] unchanged.
  - Response: hit = 1, slot = s, evict_valid = 0. hit_cnt += 1.
- On accept, miss with tuser = 1:
  - Victim v = order[DEPTH-1].
  - Response: evict_valid = valid[v], evict_tag = tag[v].
  - Then tag[v] = tdata, valid[v] = 1, v promoted to MRU.
  - Response slot = v, hit = 0. miss_cnt += 1.
- On accept, miss with tuser = 0:
  - No state change except miss_cnt += 1.
  - Response: hit = 0, slot = 0, evict_valid = 0.
- Invariant: all invalid slots occupy the tail of order, so allocation always uses an invalid slot before evicting a valid one.
- Invalidate (inv_valid = 1, flush = 0):
  - If inv_tag hits slot s: valid[s] = 0 and s is demoted to order[DEPTH-1], with the entries after it shifting up one position.
  - If it misses: no effect.
  - Takes one cycle; no lookup is accepted in that cycle.
- Flush:
  - All valid = 0, order[i] = i; takes priority over inv_valid.
  - Counters and an in-flight response are unaffected.
- Back-to-back lookups of the same tag:
  - The second lookup sees the state updated by the first, e.g. allocate then hit.
- A lookup is a pure function of the state at the accept edge; a stalled response does not change the state.

Decomposition:
- Package lru_cache_pkg:
  - clogb2 function and the SLOT_W derivation.
  - rsp_t struct (hit, slot, evict_valid, evict_tag).
  - Reset-tag constant.
- Sub-module lru_order_ctrl, which owns the order vector:
  - Inputs: promote_en / promote_slot, demote_en / demote_slot, reset_order.
  - Outputs: lru_slot and the position-of-slot lookup.
  - The top module holds the tags, valid bits, compare logic, handshake and counters.

Test Plan:
1. Reset, then four allocating lookups of tags 0x10, 0x11, 0x12, 0x13 (DEPTH = 4) -> slots 3, 2, 1, 0; all misses, evict_valid = 0, miss_cnt = 4.
2. Lookup 0x10 with allocate -> hit, slot 3; then lookup 0x14 with allocate -> victim is the slot holding 0x11 (slot 2), evict_valid = 1, evict_tag = 0x11.
3. Probe (tuser = 0) of absent tag 0x99 -> hit = 0, slot = 0, no state change; a following probe of 0x99 also misses; miss_cnt increments twice.
4. Invalidate 0x12, then allocate 0x20 -> 0x20 reuses slot 1 with evict_valid = 0; lookup 0x12 misses.
5. Hold m_rsp_tready low for 5 cycles during a stream of lookups -> s_lkp_tready goes low after one response is pending; the response payload stays stable; no lookup is lost or duplicated.
6. Flush mid-stream, then assert rstn low while m_rsp_tvalid = 1 -> after the flush every tag misses; after reset all outputs are 0 and order is the identity.

Source files
------------

// File: rtl/lru_cache_pkg.sv
// Shared types and helpers for the LRU tag directory.
package lru_cache_pkg;

    // Widest tag / slot index a response can carry.
    localparam int TAG_W_MAX  = 128;
    localparam int SLOT_W_MAX = 6;

    // Tag loaded into every slot at reset.
    localparam logic [47:0] RESET_TAG_DEF = 48'h0000_DEADC0DE;

    // Bits needed to represent value (at least 1).
    function automatic int clogb2(input int value);
        int n;
        n = 1;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) n = i + 1;
        end
        return n;
    endfunction

    // Slot index width for a given number of slots.
    function automatic int slot_w(input int depth);
        return clogb2(depth - 1);
    endfunction

    localparam int SLOT_W_DEF = slot_w(8);

    // Registered lookup response; fields are zero-extended to the max widths.
    typedef struct packed {
        logic                  hit;
        logic [SLOT_W_MAX-1:0] slot;
        logic                  evict_valid;
        logic [TAG_W_MAX-1:0]  evict_tag;
    } rsp_t;

endpackage

// File: rtl/lru_tag_cache_if.sv
// Lookup request / response stream bundle for the LRU tag directory.
interface lru_tag_cache_if #(
    parameter int TAGS_WIDTH = 48,
    parameter int SLOT_W     = lru_cache_pkg::SLOT_W_DEF
);
    logic                  s_lkp_tvalid;
    logic                  s_lkp_tready;
    logic [TAGS_WIDTH-1:0] s_lkp_tdata;
    logic                  s_lkp_tuser;

    logic                  m_rsp_tvalid;
    logic                  m_rsp_tready;
    logic                  m_rsp_hit;
    logic [SLOT_W-1:0]     m_rsp_slot;
    logic                  m_rsp_evict_valid;
    logic [TAGS_WIDTH-1:0] m_rsp_evict_tag;

    // Requester side: issues lookups, consumes responses.
    modport master (
        output s_lkp_tvalid, s_lkp_tdata, s_lkp_tuser, m_rsp_tready,
        input  s_lkp_tready, m_rsp_tvalid, m_rsp_hit, m_rsp_slot,
               m_rsp_evict_valid, m_rsp_evict_tag
    );

    // Directory side.
    modport slave (
        input  s_lkp_tvalid, s_lkp_tdata, s_lkp_tuser, m_rsp_tready,
        output s_lkp_tready, m_rsp_tvalid, m_rsp_hit, m_rsp_slot,
               m_rsp_evict_valid, m_rsp_evict_tag
    );
endinterface

// File: rtl/lru_order_ctrl.sv
// Recency order of slots: order_q[0] is MRU, order_q[DEPTH-1] is LRU.
module lru_order_ctrl
    import lru_cache_pkg::*;
#(
    parameter  int DEPTH  = 8,
    localparam int SLOT_W = slot_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         reset_order,
    input  logic                         promote_en,
    input  logic [SLOT_W-1:0]            promote_slot,
    input  logic                         demote_en,
    input  logic [SLOT_W-1:0]            demote_slot,
    output logic [SLOT_W-1:0]            lru_slot,
    output logic [DEPTH-1:0][SLOT_W-1:0] slot_pos
);

    logic [DEPTH-1:0][SLOT_W-1:0] order_q;
    logic [DEPTH-1:0][SLOT_W-1:0] order_d;
    logic [SLOT_W-1:0]            pro_pos;
    logic [SLOT_W-1:0]            dem_pos;

    assign lru_slot = order_q[DEPTH-1];
    assign pro_pos  = slot_pos[promote_slot];
    assign dem_pos  = slot_pos[demote_slot];

    // Inverse permutation: position currently held by each slot.
    always_comb begin
        slot_pos = '0;
        for (int p = 0; p < DEPTH; p++) begin
            slot_pos[order_q[p]] = SLOT_W'(p);
        end
    end

    // Next order: identity on reset, shift-to-tail on demote, shift-to-head on promote.
    always_comb begin
        order_d = order_q;
        if (reset_order) begin
            for (int p = 0; p < DEPTH; p++) order_d[p] = SLOT_W'(p);
        end else if (demote_en) begin
            for (int p = 0; p < DEPTH - 1; p++) begin
                if (p >= int'(dem_pos)) order_d[p] = order_q[p+1];
            end
            order_d[DEPTH-1] = demote_slot;
        end else if (promote_en) begin
            for (int p = 1; p < DEPTH; p++) begin
                if (p <= int'(pro_pos)) order_d[p] = order_q[p-1];
            end
            order_d[0] = promote_slot;
        end
    end

    // Order register, identity after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int p = 0; p < DEPTH; p++) order_q[p] <= SLOT_W'(p);
        end else begin
            order_q <= order_d;
        end
    end

endmodule

// File: rtl/lru_tag_cache.sv
// Fully associative LRU tag directory with allocate/probe lookups,
// invalidation, flush and hit/miss statistics.
module lru_tag_cache
    import lru_cache_pkg::*;
#(
    parameter  int                    TAGS_WIDTH  = 48,
    parameter  int                    CACHE_DEPTH = 8,
    parameter  int                    CNT_WIDTH   = 32,
    parameter  logic [TAGS_WIDTH-1:0] RESET_TAG   = TAGS_WIDTH'(RESET_TAG_DEF),
    localparam int                    SLOT_W      = slot_w(CACHE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    lru_tag_cache_if.slave        lkp,
    input  logic                  inv_valid,
    input  logic [TAGS_WIDTH-1:0] inv_tag,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    logic [CACHE_DEPTH-1:0][TAGS_WIDTH-1:0] tag_q;
    logic [CACHE_DEPTH-1:0]                 valid_q;

    logic                  lkp_hit;
    logic [SLOT_W-1:0]     lkp_slot;
    logic                  inv_hit;
    logic [SLOT_W-1:0]     inv_slot;
    logic                  accept;
    logic                  alloc;
    logic [SLOT_W-1:0]     lru_slot;
    logic [CACHE_DEPTH-1:0][SLOT_W-1:0] slot_pos;

    rsp_t rsp_d;
    rsp_t rsp_q;
    logic rsp_valid_q;

    // Only the low bits of the response fields and the position map are consumed here.
    logic unused_rsp;
    logic unused_pos;
    assign unused_rsp = ^rsp_q;
    assign unused_pos = ^slot_pos;

    // Tag match for lookup and invalidate; lowest matching index wins.
    always_comb begin
        lkp_hit  = 1'b0;
        lkp_slot = '0;
        inv_hit  = 1'b0;
        inv_slot = '0;
        for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lkp.s_lkp_tdata) begin
                lkp_hit  = 1'b1;
                lkp_slot = SLOT_W'(i);
            end
            if (valid_q[i] && tag_q[i] == inv_tag) begin
                inv_hit  = 1'b1;
                inv_slot = SLOT_W'(i);
            end
        end
    end

    // Invalidate and flush own the cycle, so lookups stall while they are up.
    assign lkp.s_lkp_tready = (!rsp_valid_q | lkp.m_rsp_tready) & !inv_valid & !flush;
    assign accept           = lkp.s_lkp_tvalid & lkp.s_lkp_tready;
    assign alloc            = accept & !lkp_hit & lkp.s_lkp_tuser;

    lru_order_ctrl #(.DEPTH(CACHE_DEPTH)) u_order (
        .clk          (clk),
        .rstn         (rstn),
        .reset_order  (flush),
        .promote_en   (accept & (lkp_hit | lkp.s_lkp_tuser)),
        .promote_slot (lkp_hit ? lkp_slot : lru_slot),
        .demote_en    (inv_valid & !flush & inv_hit),
        .demote_slot  (inv_slot),
        .lru_slot     (lru_slot),
        .slot_pos     (slot_pos)
    );

    // Response for the lookup presented this cycle, taken from pre-update state.
    always_comb begin
        rsp_d     = '0;
        rsp_d.hit = lkp_hit;
        if (lkp_hit) begin
            rsp_d.slot = SLOT_W_MAX'(lkp_slot);
        end else if (lkp.s_lkp_tuser) begin
            rsp_d.slot        = SLOT_W_MAX'(lru_slot);
            rsp_d.evict_valid = valid_q[lru_slot];
            rsp_d.evict_tag   = TAG_W_MAX'(tag_q[lru_slot]);
        end
    end

    // Response register: load on accept, hold until the consumer takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_d;
        end else if (lkp.m_rsp_tready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign lkp.m_rsp_tvalid      = rsp_valid_q;
    assign lkp.m_rsp_hit         = rsp_q.hit;
    assign lkp.m_rsp_slot        = rsp_q.slot[SLOT_W-1:0];
    assign lkp.m_rsp_evict_valid = rsp_q.evict_valid;
    assign lkp.m_rsp_evict_tag   = rsp_q.evict_tag[TAGS_WIDTH-1:0];

    // Tag and valid storage: flush clears all, invalidate clears one, allocate fills the LRU slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            tag_q   <= {CACHE_DEPTH{RESET_TAG}};
        end else if (flush) begin
            valid_q <= '0;
        end else if (inv_valid) begin
            if (inv_hit) valid_q[inv_slot] <= 1'b0;
        end else if (alloc) begin
            tag_q[lru_slot]   <= lkp.s_lkp_tdata;
            valid_q[lru_slot] <= 1'b1;
        end
    end

    // Wrapping hit/miss statistics, counted at accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (lkp_hit) hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
            else         miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
